// File: rtl/hex_display_scanner.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Shadows a packed hex word, decodes 0-F and scans one digit per refresh slot.
module hex_display_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              display,
  output logic                    dp_n,
  output logic                    scan_tick
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              display_q, display_d;
  logic                    dp_n_q, dp_n_d;
  logic                    tick_q, tick_d;

  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [3:0]              cur_nib;
  logic                    cur_en;
  logic                    cur_dp;
  logic                    cur_lead;
  logic                    cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // lead_zero[i]: every shadow nibble from the top digit down to i is zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (value_q[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_en   = 1'b0;
    cur_dp   = 1'b0;
    cur_lead = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib  = value_q[4*i +: 4];
        cur_en   = en_q[i];
        cur_dp   = dp_q[i];
        cur_lead = lead_zero[i];
      end
    end
    // Digit 0 always shows, even when the whole word is zero.
    cur_blank = ~cur_en | (lz_suppress & (idx_q != '0) & cur_lead);
  end

  always_comb begin
    value_d = load ? value    : value_q;
    en_d    = load ? digit_en : en_q;
    dp_d    = load ? dp       : dp_q;

    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    tick_d = 1'b0;
    if (cnt_q == CntLast) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      idx_d  = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end

    anode_d   = '1;
    display_d = 7'b1111111;
    dp_n_d    = 1'b1;
    if (tick_d) begin
      // Anti-ghost slot: anodes off while the cathodes keep their old pattern.
      display_d = display_q;
      dp_n_d    = dp_n_q;
    end else if (!cur_blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        anode_d[i] = (idx_q != IDX_W'(i));
      end
      display_d = seg_decode(cur_nib);
      dp_n_d    = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      value_q   <= '0;
      en_q      <= '0;
      dp_q      <= '0;
      anode_q   <= '1;
      display_q <= 7'b1111111;
      dp_n_q    <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      value_q   <= value_d;
      en_q      <= en_d;
      dp_q      <= dp_d;
      anode_q   <= anode_d;
      display_q <= display_d;
      dp_n_q    <= dp_n_d;
      tick_q    <= tick_d;
    end
  end

  assign anode     = anode_q;
  assign display   = display_q;
  assign dp_n      = dp_n_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner (4 digits, 4-cycle slots) with a
// cycle model of the refresh counter and a table of per-digit expectations.
module tb_hex_display_scanner;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  dp = '0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  display;
  logic        dp_n;
  logic        scan_tick;

  hex_display_scanner #(
    .NUM_DIGITS (ND),
    .IDX_W      (2),
    .REFRESH_DIV(DIV),
    .CNT_W      (3)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .digit_en   (digit_en),
    .dp         (dp),
    .lz_suppress(lz_suppress),
    .anode      (anode),
    .display    (display),
    .dp_n       (dp_n),
    .scan_tick  (scan_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic        lz;
    logic [15:0] an;   // {d3,d2,d1,d0}
    logic [27:0] seg;  // {d3,d2,d1,d0}
    logic [3:0]  dpn;  // {d3,d2,d1,d0}
  } vec_t;

  localparam logic [6:0] Off = 7'b1111111;

  int   checks = 0;
  int   errors = 0;
  int   m_cnt = 0;
  int   m_idx = 0;
  bit   m_tick = 1'b0;
  bit   mon_en = 1'b0;
  logic [6:0] prev_disp = Off;
  logic       prev_dpn = 1'b1;

  vec_t       vecs [6];
  logic [6:0] dec [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // One clock: advance the reference counter model, then sample at negedge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_cnt = 0; m_idx = 0; m_tick = 1'b0;
    end else if (m_cnt == DIV - 1) begin
      m_cnt = 0; m_idx = (m_idx + 1) % ND; m_tick = 1'b1;
    end else begin
      m_cnt++; m_tick = 1'b0;
    end
    @(negedge clk);
    if (mon_en) begin
      check("scan_tick", 32'(scan_tick), 32'(m_tick));
      if (m_tick) check("blank_slot", {anode, display, dp_n}, {4'hF, prev_disp, prev_dpn});
    end
    prev_disp = display;
    prev_dpn  = dp_n;
  endtask

  task automatic wait_at(input int cnt, input int idx, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (m_cnt == cnt && m_idx == idx) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for cnt=%0d idx=%0d", name, cnt, idx);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d,
                         input logic lz);
    value = v; digit_en = en; dp = d; lz_suppress = lz; load = 1'b1;
    step();
    load = 1'b0;
    step();
  endtask

  task automatic count_to_tick(input string name);
    int n;
    n = 0;
    while (!scan_tick && n < 10) begin
      step();
      n++;
      check({name, "_blank"}, {anode, display, dp_n}, {4'hF, Off, 1'b1});
    end
    check({name, "_latency"}, n, DIV);
  endtask

  initial begin
    vec_t cur;
    vecs[0] = '{16'h1A3F, 4'hF, 4'b0100, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}, 4'b1011};
    vecs[1] = '{16'h0005, 4'hF, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {Off, Off, Off, 7'b0010010}, 4'b1111};
    vecs[2] = '{16'h0000, 4'hF, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {Off, Off, Off, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h8888, 4'b1010, 4'b0000, 1'b0, {4'b0111, 4'b1111, 4'b1101, 4'b1111},
                {7'b0000000, Off, 7'b0000000, Off}, 4'b1111};
    // Inner zero stays lit; dp on a suppressed leading zero does not light it.
    vecs[4] = '{16'h0305, 4'hF, 4'b1100, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {Off, 7'b0110000, 7'b1000000, 7'b0010010}, 4'b1011};
    vecs[5] = '{16'h2345, 4'b0111, 4'b1001, 1'b0, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {Off, 7'b0110000, 7'b0011001, 7'b0010010}, 4'b1110};

    dec = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reset and idle scan with empty shadow
    reset = 1'b1;
    step();
    step();
    check("reset_outputs", {anode, display, dp_n, scan_tick}, {4'hF, Off, 1'b1, 1'b0});
    mon_en = 1'b1;
    reset = 1'b0;
    count_to_tick("idle_first_tick");
    for (int n = 0; n < 2 * ND * DIV; n++) begin
      step();
      check("idle_blank", {anode, display, dp_n}, {4'hF, Off, 1'b1});
    end

    // Table of loaded words, checked in the last cycle of each digit slot
    for (int v = 0; v < 6; v++) begin
      cur = vecs[v];
      do_load(cur.value, cur.en, cur.dp, cur.lz);
      for (int i = 0; i < ND; i++) begin
        wait_at(DIV - 1, i, "vec_slot");
        check($sformatf("vec%0d_d%0d_anode", v, i), 32'(anode), 32'(cur.an[4*i +: 4]));
        check($sformatf("vec%0d_d%0d_disp", v, i), 32'(display), 32'(cur.seg[7*i +: 7]));
        check($sformatf("vec%0d_d%0d_dpn", v, i), 32'(dp_n), 32'(cur.dpn[i]));
      end
    end

    // Input changes without load are ignored
    value = 16'hFFFF; digit_en = 4'h0; dp = 4'h0;
    step();
    wait_at(DIV - 1, 0, "noload_slot");
    check("noload_d0", {anode, display, dp_n}, {4'b1110, 7'b0010010, 1'b0});

    // Load coincident with scan_tick into digit 0, sweeping all 16 codes
    for (int c = 0; c < 16; c++) begin
      wait_at(0, 0, "sweep_tick");
      check("sweep_tick_hi", 32'(scan_tick), 32'd1);
      value = 16'(c); digit_en = 4'h1; dp = 4'h0; lz_suppress = 1'b0; load = 1'b1;
      step();
      load = 1'b0;
      wait_at(DIV - 1, 0, "sweep_slot");
      check($sformatf("sweep_%0h", c), {anode, display, dp_n}, {4'b1110, dec[c], 1'b1});
    end

    // Reset mid-slot (cnt=2, idx=2)
    do_load(16'h1A3F, 4'hF, 4'b0100, 1'b0);
    wait_at(2, 2, "pre_reset");
    check("pre_reset_d2", {anode, display, dp_n}, {4'b1011, 7'b0001000, 1'b0});
    reset = 1'b1;
    step();
    check("midreset_outputs", {anode, display, dp_n, scan_tick}, {4'hF, Off, 1'b1, 1'b0});
    reset = 1'b0;
    count_to_tick("post_reset_tick");
    for (int n = 0; n < ND * DIV; n++) begin
      step();
      check("shadow_cleared", {anode, display, dp_n}, {4'hF, Off, 1'b1});
    end

    // Scan restarts at digit 0: load right after release, digit 0 shows next edge
    reset = 1'b1;
    step();
    reset = 1'b0;
    value = 16'h1A3F; digit_en = 4'hF; dp = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    step();
    check("restart_idx0", {anode, display, dp_n}, {4'b1110, 7'b0001110, 1'b1});
    step();
    step();
    check("restart_tick", 32'(scan_tick), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
